// File: rtl/axi4_lite_regs.sv
// ---------------------------------------------------------------------------
// axi4_lite_regs
//   AXI4-Lite responder exposing a bank of REG_N read/write registers.
//   Write address and write data are buffered independently (one entry
//   each). A write commits once both are held and the B channel can take a
//   response. Every transaction gets exactly one response. Out-of-range
//   addresses return SLVERR.
//
// Ports
//   ACLK, ARESETn          clock, async active-low reset
//   AW*  (VALID/READY/ADDR/PROT)  write address channel (PROT ignored)
//   W*   (VALID/READY/DATA/STRB)  write data channel
//   B*   (VALID/READY/RESP)       write response channel
//   AR*  (VALID/READY/ADDR/PROT)  read address channel (PROT ignored)
//   R*   (VALID/READY/DATA/RESP)  read data channel
//   regs_o    flattened register contents, reg i at [i*DATA_W +: DATA_W]
//   wr_stb_o  one-cycle pulse on bit i the cycle after a write commits to reg i
// ---------------------------------------------------------------------------
module axi4_lite_regs #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_N  = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [ADDR_W-1:0]         AWADDR,
    input  logic [2:0]                AWPROT,
    input  logic                      WVALID,
    output logic                      WREADY,
    input  logic [DATA_W-1:0]         WDATA,
    input  logic [DATA_W/8-1:0]       WSTRB,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic [1:0]                BRESP,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    input  logic [ADDR_W-1:0]         ARADDR,
    input  logic [2:0]                ARPROT,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [DATA_W-1:0]         RDATA,
    output logic [1:0]                RRESP,
    output logic [REG_N*DATA_W-1:0]   regs_o,
    output logic [REG_N-1:0]          wr_stb_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned BYTE_W = $clog2(STRB_W);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Protection bits carry no meaning for this register bank.
    logic [5:0] unused_prot;
    assign unused_prot = {AWPROT, ARPROT};

    // Registered state
    logic                aw_full_q, aw_full_d;
    logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
    logic                w_full_q,  w_full_d;
    logic [DATA_W-1:0]   w_data_q,  w_data_d;
    logic [STRB_W-1:0]   w_strb_q,  w_strb_d;
    logic                bvalid_q,  bvalid_d;
    logic [1:0]          bresp_q,   bresp_d;
    logic                rvalid_q,  rvalid_d;
    logic [1:0]          rresp_q,   rresp_d;
    logic [DATA_W-1:0]   rdata_q,   rdata_d;
    logic [REG_N-1:0]    wr_stb_q,  wr_stb_d;
    logic [DATA_W-1:0]   regs_q [REG_N];
    logic [DATA_W-1:0]   regs_d [REG_N];

    // Decode and handshake helpers
    logic [ADDR_W-1:0]   aw_word;
    logic [ADDR_W-1:0]   ar_word;
    logic                aw_in_range;
    logic                ar_in_range;
    logic                commit;
    logic                ar_hs;
    logic [DATA_W-1:0]   rd_val;

    assign AWREADY  = !aw_full_q;
    assign WREADY   = !w_full_q;
    assign ARREADY  = !rvalid_q || RREADY;
    assign BVALID   = bvalid_q;
    assign BRESP    = bresp_q;
    assign RVALID   = rvalid_q;
    assign RRESP    = rresp_q;
    assign RDATA    = rdata_q;
    assign wr_stb_o = wr_stb_q;

    always_comb begin
        aw_word     = aw_addr_q >> BYTE_W;
        ar_word     = ARADDR >> BYTE_W;
        aw_in_range = (aw_word < ADDR_W'(REG_N));
        ar_in_range = (ar_word < ADDR_W'(REG_N));
        // A pending response may be replaced in the same cycle it is accepted.
        commit      = aw_full_q && w_full_q && (!bvalid_q || BREADY);
        ar_hs       = ARVALID && ARREADY;
    end

    // Write path: buffers, register update, strobe and B response
    always_comb begin
        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        wr_stb_d  = '0;
        for (int unsigned i = 0; i < REG_N; i++) begin
            regs_d[i] = regs_q[i];
        end

        // READY is only ever high with the buffer empty, so a commit and a
        // new handshake on the same buffer cannot coincide.
        if (AWVALID && !aw_full_q) begin
            aw_full_d = 1'b1;
            aw_addr_d = AWADDR;
        end
        if (WVALID && !w_full_q) begin
            w_full_d = 1'b1;
            w_data_d = WDATA;
            w_strb_d = WSTRB;
        end

        if (bvalid_q && BREADY) begin
            bvalid_d = 1'b0;
        end

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_in_range ? RESP_OKAY : RESP_SLVERR;
            for (int unsigned i = 0; i < REG_N; i++) begin
                if (aw_in_range && (aw_word == ADDR_W'(i))) begin
                    wr_stb_d[i] = 1'b1;
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) begin
                            regs_d[i][b*8 +: 8] = w_data_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Read path: samples the pre-update register value on the AR handshake
    always_comb begin
        rd_val = '0;
        for (int unsigned i = 0; i < REG_N; i++) begin
            if (ar_word == ADDR_W'(i)) begin
                rd_val = regs_q[i];
            end
        end

        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (rvalid_q && RREADY) begin
            rvalid_d = 1'b0;
        end
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
            rdata_d  = ar_in_range ? rd_val : '0;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int unsigned i = 0; i < REG_N; i++) begin
            regs_o[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            wr_stb_q  <= '0;
            regs_q    <= '{default: '0};
        end else begin
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            wr_stb_q  <= wr_stb_d;
            regs_q    <= regs_d;
        end
    end

endmodule

// File: tb/tb_axi4_lite_regs.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_regs
//   Directed bench for axi4_lite_regs (ADDR_W=32, DATA_W=32, REG_N=16).
//   A vector table drives single writes/reads with hand-computed results;
//   hand-written sequences cover buffering with BREADY low, back-to-back
//   reads, same-edge write/read ordering and reset mid-transaction.
// ---------------------------------------------------------------------------
module tb_axi4_lite_regs;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_N  = 16;

    logic                    ACLK;
    logic                    ARESETn;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [ADDR_W-1:0]       AWADDR;
    logic [2:0]              AWPROT;
    logic                    WVALID;
    logic                    WREADY;
    logic [DATA_W-1:0]       WDATA;
    logic [DATA_W/8-1:0]     WSTRB;
    logic                    BVALID;
    logic                    BREADY;
    logic [1:0]              BRESP;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [ADDR_W-1:0]       ARADDR;
    logic [2:0]              ARPROT;
    logic                    RVALID;
    logic                    RREADY;
    logic [DATA_W-1:0]       RDATA;
    logic [1:0]              RRESP;
    logic [REG_N*DATA_W-1:0] regs_o;
    logic [REG_N-1:0]        wr_stb_o;

    axi4_lite_regs #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .AWADDR   (AWADDR),
        .AWPROT   (AWPROT),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .BRESP    (BRESP),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .ARADDR   (ARADDR),
        .ARPROT   (ARPROT),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .regs_o   (regs_o),
        .wr_stb_o (wr_stb_o)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;

    logic [31:0] model [REG_N];

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic [15:0] exp_stb;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // AW and W presented together with BREADY high; checks response timing.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] er, input logic [15:0] es);
        @(negedge ACLK);
        chk("awready_idle", 64'(AWREADY), 64'(1));
        chk("wready_idle", 64'(WREADY), 64'(1));
        AWVALID = 1'b1; AWADDR = a;
        WVALID  = 1'b1; WDATA = d; WSTRB = s;
        BREADY  = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("bvalid_early", 64'(BVALID), 64'(0));
        chk("wr_stb_early", 64'(wr_stb_o), 64'(0));
        @(negedge ACLK);
        chk("bvalid", 64'(BVALID), 64'(1));
        chk("bresp", 64'(BRESP), 64'(er));
        chk("wr_stb", 64'(wr_stb_o), 64'(es));
        @(negedge ACLK);
        chk("bvalid_clear", 64'(BVALID), 64'(0));
        chk("wr_stb_clear", 64'(wr_stb_o), 64'(0));
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
        @(negedge ACLK);
        ARVALID = 1'b1; ARADDR = a; RREADY = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("rvalid", 64'(RVALID), 64'(1));
        chk("rdata", 64'(RDATA), 64'(ed));
        chk("rresp", 64'(RRESP), 64'(er));
        @(negedge ACLK);
        chk("rvalid_clear", 64'(RVALID), 64'(0));
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < int'(REG_N); i++) begin
            chk($sformatf("%s_reg%0d", tag, i), 64'(regs_o[i*DATA_W +: DATA_W]), 64'(model[i]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_awready"}, 64'(AWREADY), 64'(1));
        chk({tag, "_wready"}, 64'(WREADY), 64'(1));
        chk({tag, "_arready"}, 64'(ARREADY), 64'(1));
        chk({tag, "_bvalid"}, 64'(BVALID), 64'(0));
        chk({tag, "_rvalid"}, 64'(RVALID), 64'(0));
        chk({tag, "_bresp"}, 64'(BRESP), 64'(0));
        chk({tag, "_rresp"}, 64'(RRESP), 64'(0));
        chk({tag, "_rdata"}, 64'(RDATA), 64'(0));
        chk({tag, "_wr_stb"}, 64'(wr_stb_o), 64'(0));
        chk({tag, "_regs_zero"}, 64'(regs_o == '0), 64'(1));
    endtask

    initial begin
        //            wr   addr          data          strb  exp_rdata     resp   stb
        vecs[0]  = '{1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 4'hF, 32'h0,        2'b00, 16'h0008};
        vecs[1]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 32'hDEAD_BEEF, 2'b00, 16'h0};
        vecs[2]  = '{1'b1, 32'h0000_000C, 32'h1122_3344, 4'h5, 32'h0,        2'b00, 16'h0008};
        vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0,         4'h0, 32'hDE22_BE44, 2'b00, 16'h0};
        vecs[4]  = '{1'b1, 32'h0000_0040, 32'h1234_5678, 4'hF, 32'h0,        2'b10, 16'h0};
        vecs[5]  = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 32'h0,        2'b10, 16'h0};
        vecs[6]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 32'h0,        2'b00, 16'h0001};
        vecs[7]  = '{1'b1, 32'h0000_0004, 32'h0102_0304, 4'hF, 32'h0,        2'b00, 16'h0002};
        vecs[8]  = '{1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'hF, 32'h0,        2'b00, 16'h0004};
        vecs[9]  = '{1'b1, 32'h0000_003C, 32'hFFFF_FFFF, 4'h0, 32'h0,        2'b00, 16'h8000};
        vecs[10] = '{1'b0, 32'h0000_003C, 32'h0,         4'h0, 32'h0,        2'b00, 16'h0};
        vecs[11] = '{1'b1, 32'h0000_003E, 32'h00AB_0000, 4'h4, 32'h0,        2'b00, 16'h8000};
        vecs[12] = '{1'b0, 32'h0000_003F, 32'h0,         4'h0, 32'h00AB_0000, 2'b00, 16'h0};
        vecs[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,        2'b10, 16'h0};

        for (int i = 0; i < int'(REG_N); i++) model[i] = '0;

        ARESETn = 1'b0;
        AWVALID = 1'b0; AWADDR = '0; AWPROT = '0;
        WVALID  = 1'b0; WDATA  = '0; WSTRB  = '0;
        BREADY  = 1'b0;
        ARVALID = 1'b0; ARADDR = '0; ARPROT = '0;
        RREADY  = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(negedge ACLK);
        ARESETn = 1'b1;

        // Table-driven single transactions
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp, vecs[i].exp_stb);
                if (vecs[i].exp_resp == 2'b00) begin
                    for (int b = 0; b < 4; b++) begin
                        if (vecs[i].strb[b]) model[vecs[i].addr[5:2]][b*8 +: 8] = vecs[i].data[b*8 +: 8];
                    end
                end
            end else begin
                axi_read(vecs[i].addr, vecs[i].exp_rdata, vecs[i].exp_resp);
            end
        end
        check_regs("after_table");

        // W arrives 3 cycles before AW, BREADY low while a second pair queues
        BREADY = 1'b0;
        @(negedge ACLK);
        WVALID = 1'b1; WDATA = 32'h1111_1111; WSTRB = 4'hF;
        @(negedge ACLK);
        chk("early_w_wready_low", 64'(WREADY), 64'(0));
        WDATA = 32'h2222_2222;
        @(negedge ACLK);
        @(negedge ACLK);
        chk("late_aw_awready", 64'(AWREADY), 64'(1));
        AWVALID = 1'b1; AWADDR = 32'h10;
        @(negedge ACLK);
        chk("buf_full_awready", 64'(AWREADY), 64'(0));
        chk("buf_full_bvalid", 64'(BVALID), 64'(0));
        AWADDR = 32'h14;
        @(negedge ACLK);
        chk("c1_bvalid", 64'(BVALID), 64'(1));
        chk("c1_bresp", 64'(BRESP), 64'(0));
        chk("c1_wr_stb", 64'(wr_stb_o), 64'(16'h0010));
        chk("c1_awready", 64'(AWREADY), 64'(1));
        chk("c1_wready", 64'(WREADY), 64'(1));
        model[4] = 32'h1111_1111;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        chk("stall_awready", 64'(AWREADY), 64'(0));
        chk("stall_wready", 64'(WREADY), 64'(0));
        chk("stall_wr_stb", 64'(wr_stb_o), 64'(0));
        @(negedge ACLK);
        chk("stall_bvalid", 64'(BVALID), 64'(1));
        chk("stall_reg5", 64'(regs_o[5*DATA_W +: DATA_W]), 64'(0));
        @(negedge ACLK);
        chk("stall2_wready", 64'(WREADY), 64'(0));
        chk("stall2_reg4", 64'(regs_o[4*DATA_W +: DATA_W]), 64'(32'h1111_1111));
        BREADY = 1'b1;
        @(negedge ACLK);
        chk("c2_bvalid_held", 64'(BVALID), 64'(1));
        chk("c2_wr_stb", 64'(wr_stb_o), 64'(16'h0020));
        chk("c2_reg5", 64'(regs_o[5*DATA_W +: DATA_W]), 64'(32'h2222_2222));
        model[5] = 32'h2222_2222;
        @(negedge ACLK);
        chk("c2_bvalid_clear", 64'(BVALID), 64'(0));
        chk("c2_wr_stb_clear", 64'(wr_stb_o), 64'(0));

        // Back-to-back reads with RREADY held high
        @(negedge ACLK);
        RREADY = 1'b1; ARVALID = 1'b1; ARADDR = 32'h0;
        @(negedge ACLK);
        chk("b2b0_rvalid", 64'(RVALID), 64'(1));
        chk("b2b0_rdata", 64'(RDATA), 64'(32'hA5A5_A5A5));
        chk("b2b0_arready", 64'(ARREADY), 64'(1));
        ARADDR = 32'h4;
        @(negedge ACLK);
        chk("b2b1_rvalid", 64'(RVALID), 64'(1));
        chk("b2b1_rdata", 64'(RDATA), 64'(32'h0102_0304));
        ARADDR = 32'h8;
        @(negedge ACLK);
        chk("b2b2_rvalid", 64'(RVALID), 64'(1));
        chk("b2b2_rdata", 64'(RDATA), 64'(32'hCAFE_F00D));
        ARVALID = 1'b0;
        @(negedge ACLK);
        chk("b2b_rvalid_clear", 64'(RVALID), 64'(0));

        // Write to reg 1 commits on the same edge as a read of reg 1
        @(negedge ACLK);
        AWVALID = 1'b1; AWADDR = 32'h4;
        WVALID  = 1'b1; WDATA  = 32'h55AA_55AA; WSTRB = 4'hF;
        BREADY  = 1'b1;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0;
        ARVALID = 1'b1; ARADDR = 32'h4; RREADY = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        chk("same_edge_rdata_old", 64'(RDATA), 64'(32'h0102_0304));
        chk("same_edge_bvalid", 64'(BVALID), 64'(1));
        chk("same_edge_wr_stb", 64'(wr_stb_o), 64'(16'h0002));
        model[1] = 32'h55AA_55AA;
        axi_read(32'h4, 32'h55AA_55AA, 2'b00);
        check_regs("after_seq");

        // Reset while a write is buffered and a read response is pending
        @(negedge ACLK);
        RREADY  = 1'b0; BREADY = 1'b0;
        AWVALID = 1'b1; AWADDR = 32'h18;
        WVALID  = 1'b1; WDATA  = 32'h7777_7777; WSTRB = 4'hF;
        ARVALID = 1'b1; ARADDR = 32'h0;
        @(negedge ACLK);
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        ARESETn = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);
        @(negedge ACLK);
        chk("post_rst_bvalid", 64'(BVALID), 64'(0));
        chk("post_rst_wr_stb", 64'(wr_stb_o), 64'(0));
        chk("post_rst_regs_zero", 64'(regs_o == '0), 64'(1));
        axi_read(32'h18, 32'h0, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
